minmax_controller: RTL and testbench
====================================

// Module: minmax_controller
// PURPOSE
//  Sequencer directly upstream of the signed min/max tracking datapath. Accepts a burst of
//  COUNT signed samples over a valid/ready handshake and drives the datapath's clear/load/data.
//  Captures the datapath's min/max once the final sample has been absorbed, then reports done.
//  Turns the free-running datapath into a start/done transaction unit for the surrounding system.
// PARAMETERS
//  DATA_W  32  sample width, signed two's complement; must match the datapath
//  CNT_W   16  width of the sample-count field; a burst is 1..2^CNT_W-1 samples
// PORTS
//  clock         in   1       system clock; all state changes on the rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  start         in   1       begin a burst; sampled only in IDLE
//  count         in   CNT_W   number of samples in the burst; latched on an accepted start
//  abort         in   1       cancel the burst in progress
//  in_valid      in   1       upstream sample valid
//  in_data       in   DATA_W  upstream sample (signed)
//  in_ready      out  1       controller can accept a sample
//  dp_clear      out  1       to datapath clear
//  dp_load       out  1       to datapath load
//  dp_data       out  DATA_W  to datapath data
//  dp_min        in   DATA_W  from datapath min
//  dp_max        in   DATA_W  from datapath max
//  busy          out  1       burst in progress (any state other than IDLE)
//  done          out  1       one-cycle pulse when results are captured
//  result_valid  out  1       result_min/max hold the results of the last completed burst
//  result_min    out  DATA_W  captured minimum
//  result_max    out  DATA_W  captured maximum
//  remaining     out  CNT_W   samples still to accept
//  err_zero      out  1       one-cycle pulse: start with count==0 (rejected)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (result_min/max=0, dp_data=0, remaining=0).
//  All outputs are registered; no combinational path from inputs to outputs.
//  States:
//   IDLE    busy=0. start&count!=0 -> remaining<=count, result_valid<=0, goto CLEAR.
//           start&count==0 -> err_zero pulse, stay IDLE. done is deasserted on the next cycle.
//   CLEAR   dp_clear=1 for exactly one cycle; goto ACCEPT.
//   ACCEPT  in_ready=1. Handshake fires when in_valid&in_ready at the edge:
//           dp_data<=in_data, dp_load<=1 for the next cycle only, remaining<=remaining-1.
//           Fire with remaining==1 -> goto DRAIN (in_ready drops in the same edge).
//           in_valid low -> dp_load<=0; wait indefinitely.
//   DRAIN   dp_load=1 for the last sample; the datapath updates at this cycle's edge; goto CAPTURE.
//   CAPTURE result_min<=dp_min, result_max<=dp_max, result_valid<=1, done<=1; goto IDLE.
//  Latency: the edge that accepts the last sample is followed, two edges later, by done=1
//   and valid results.
//  Back-to-back bursts: start is sampled in the cycle done is high, so the minimum gap is 0.
//  abort (CLEAR/ACCEPT/DRAIN/CAPTURE): next state IDLE; dp_load, dp_clear and in_ready go to 0;
//   no done; result_valid stays 0; remaining<=0. abort has priority over a simultaneous
//   handshake or capture. abort is ignored in IDLE.
//  start while busy: ignored.
//  remaining never wraps: it is decremented only in ACCEPT and only while it is >=1.
//  Datapath sentinels: a burst of one sample yields min==max==sample.
//  reset_n low mid-burst: immediate return to the reset values; the datapath is not cleared
//   until the next CLEAR state.
// STRUCTURE
//  Package minmax_pkg: state enum (IDLE, CLEAR, ACCEPT, DRAIN, CAPTURE), DATA_W/CNT_W defaults.
//  Sub-module minmax_sample_counter: loadable down-counter with load/dec/clr and a
//   last (==1) flag.
//  The top level holds the FSM, the handshake, the dp_* registers and the result registers.
//  The bench instantiates this block with the real datapath.
// TESTING
//  1 count=4, samples 5,-3,12,0, in_valid held high -> done 2 edges after the 4th accept;
//    result_min=-3, result_max=12.
//  2 count=3, in_valid gapped (1 cycle on, 2 off), samples 7,7,7 -> min=max=7;
//    dp_load pulses exactly 3 times.
//  3 count=2, samples 32'h80000000, 32'h7FFFFFFF -> min=-2147483648, max=2147483647.
//  4 abort asserted after 2 of 5 samples -> IDLE next cycle, no done, result_valid=0;
//    a new count=1 burst with sample -9 gives min=max=-9.
//  5 count=0 start -> err_zero 1 cycle, busy stays 0; start asserted while busy -> no effect.
//  6 reset_n low mid-ACCEPT -> all outputs 0 at once; a burst after reset gives correct results.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and default widths for the min/max burst controller.
package minmax_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCEPT,
    DRAIN,
    CAPTURE
  } state_t;

endpackage

// File: rtl/minmax_sample_counter.sv
// Loadable down-counter tracking samples still owed in a burst.
// Priority is clr, then load, then dec; it saturates at zero.
module minmax_sample_counter
  import minmax_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] value_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
    end else if (clr) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (dec && (value_reg != '0)) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign value = value_reg;
  assign last  = (value_reg == CNT_W'(1));

endmodule

// File: rtl/minmax_controller.sv
// Start/done sequencer for the signed min/max datapath: clears it, streams
// a counted burst into it, then captures its min/max as the burst result.
module minmax_controller
  import minmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dp_clear,
  output logic              dp_load,
  output logic [DATA_W-1:0] dp_data,
  input  logic [DATA_W-1:0] dp_min,
  input  logic [DATA_W-1:0] dp_max,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_min,
  output logic [DATA_W-1:0] result_max,
  output logic [CNT_W-1:0]  remaining,
  output logic              err_zero
);

  state_t state_reg, state_next;

  logic fire, start_ok, start_zero, capture, kill;
  logic last;

  logic              in_ready_reg;
  logic              dp_clear_reg;
  logic              dp_load_reg;
  logic [DATA_W-1:0] dp_data_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              result_valid_reg;
  logic [DATA_W-1:0] result_min_reg;
  logic [DATA_W-1:0] result_max_reg;
  logic              err_zero_reg;

  minmax_sample_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (start_ok),
    .dec        (fire),
    .clr        (kill),
    .load_value (count),
    .value      (remaining),
    .last       (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    capture    = 1'b0;
    kill       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            start_ok   = 1'b1;
            state_next = CLEAR;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      CLEAR: state_next = ACCEPT;
      ACCEPT: begin
        if (in_valid && in_ready_reg) begin
          fire = 1'b1;
          if (last) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: state_next = CAPTURE;
      CAPTURE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // abort outranks a handshake or capture landing on the same edge
    if (abort && (state_reg != IDLE)) begin
      kill       = 1'b1;
      fire       = 1'b0;
      capture    = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_reg     <= 1'b0;
      dp_clear_reg     <= 1'b0;
      dp_load_reg      <= 1'b0;
      dp_data_reg      <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
      result_min_reg   <= '0;
      result_max_reg   <= '0;
      err_zero_reg     <= 1'b0;
    end else begin
      in_ready_reg <= (state_next == ACCEPT);
      dp_clear_reg <= (state_next == CLEAR);
      dp_load_reg  <= fire;
      busy_reg     <= (state_next != IDLE);
      done_reg     <= capture;
      err_zero_reg <= start_zero;
      if (fire) begin
        dp_data_reg <= in_data;
      end
      if (start_ok) begin
        result_valid_reg <= 1'b0;
      end else if (capture) begin
        result_valid_reg <= 1'b1;
      end
      if (capture) begin
        result_min_reg <= dp_min;
        result_max_reg <= dp_max;
      end
    end
  end

  assign in_ready     = in_ready_reg;
  assign dp_clear     = dp_clear_reg;
  assign dp_load      = dp_load_reg;
  assign dp_data      = dp_data_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign result_valid = result_valid_reg;
  assign result_min   = result_min_reg;
  assign result_max   = result_max_reg;
  assign err_zero     = err_zero_reg;

endmodule

// File: tb/tb_minmax_controller.sv
// Directed bench for minmax_controller with a behavioural min/max datapath
// and a burst-level reference model compared every cycle.
module tb_minmax_controller;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, dp_clear, dp_load;
  logic [DW-1:0] dp_data;
  logic [DW-1:0] dp_min_q = '0;
  logic [DW-1:0] dp_max_q = '0;
  logic          busy, done, result_valid, err_zero;
  logic [DW-1:0] result_min, result_max;
  logic [CW-1:0] remaining;

  int total = 0;
  int bad = 0;
  int load_pulses = 0;

  always #5 clock = ~clock;

  minmax_controller #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .count(count), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_clear(dp_clear), .dp_load(dp_load), .dp_data(dp_data),
    .dp_min(dp_min_q), .dp_max(dp_max_q), .busy(busy), .done(done),
    .result_valid(result_valid), .result_min(result_min), .result_max(result_max),
    .remaining(remaining), .err_zero(err_zero)
  );

  // signed min/max datapath: clear installs sentinels, load folds in a sample
  always @(posedge clock) begin
    if (dp_clear) begin
      dp_min_q <= 32'h7FFF_FFFF;
      dp_max_q <= 32'h8000_0000;
    end else if (dp_load) begin
      if ($signed(dp_data) < $signed(dp_min_q)) dp_min_q <= dp_data;
      if ($signed(dp_data) > $signed(dp_max_q)) dp_max_q <= dp_data;
    end
  end

  // reference model: burst phase, accepted samples and a done countdown
  int            phase = 0;  // 0 idle, 1 clearing, 2 accepting, 3 finishing
  int            wait_cnt = 0;
  logic [DW-1:0] samples[$];
  logic          e_busy = 0, e_in_ready = 0, e_clear = 0, e_load = 0;
  logic          e_done = 0, e_rv = 0, e_err = 0;
  logic [DW-1:0] e_data = '0, e_rmin = '0, e_rmax = '0;
  logic [CW-1:0] e_rem = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase = 0; wait_cnt = 0; samples.delete();
      e_busy = 0; e_in_ready = 0; e_clear = 0; e_load = 0; e_done = 0;
      e_rv = 0; e_err = 0; e_data = '0; e_rmin = '0; e_rmax = '0; e_rem = '0;
    end else begin
      e_done = 0; e_err = 0; e_clear = 0; e_load = 0;
      if (phase == 0) begin
        if (start) begin
          if (count == '0) begin
            e_err = 1;
          end else begin
            phase = 1; e_rem = count; e_rv = 0; samples.delete();
            e_busy = 1; e_clear = 1;
          end
        end
      end else if (abort) begin
        phase = 0; e_busy = 0; e_in_ready = 0; e_rem = '0;
      end else if (phase == 1) begin
        phase = 2; e_in_ready = 1;
      end else if (phase == 2) begin
        if (in_valid) begin
          samples.push_back(in_data);
          e_data = in_data; e_load = 1; e_rem = e_rem - 1'b1;
          if (e_rem == '0) begin
            phase = 3; wait_cnt = 2; e_in_ready = 0;
          end
        end
      end else begin
        wait_cnt = wait_cnt - 1;
        if (wait_cnt == 0) begin
          e_rmin = samples[0];
          e_rmax = samples[0];
          foreach (samples[i]) begin
            if ($signed(samples[i]) < $signed(e_rmin)) e_rmin = samples[i];
            if ($signed(samples[i]) > $signed(e_rmax)) e_rmax = samples[i];
          end
          e_done = 1; e_rv = 1; e_busy = 0; phase = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (dp_load === 1'b1) load_pulses++;
      chk("busy", 64'(busy), 64'(e_busy));
      chk("in_ready", 64'(in_ready), 64'(e_in_ready));
      chk("dp_clear", 64'(dp_clear), 64'(e_clear));
      chk("dp_load", 64'(dp_load), 64'(e_load));
      chk("dp_data", 64'(dp_data), 64'(e_data));
      chk("done", 64'(done), 64'(e_done));
      chk("result_valid", 64'(result_valid), 64'(e_rv));
      chk("result_min", 64'(result_min), 64'(e_rmin));
      chk("result_max", 64'(result_max), 64'(e_rmax));
      chk("remaining", 64'(remaining), 64'(e_rem));
      chk("err_zero", 64'(err_zero), 64'(e_err));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start = 1; count = n;
    tick();
    start = 0;
    $display("start count=%0d busy=%0b err_zero=%0b", n, busy, err_zero);
  endtask

  task automatic send_one(input logic [DW-1:0] v, input int gap);
    int guard;
    logic r;
    guard = 0;
    in_valid = 1; in_data = v;
    do begin
      r = in_ready;
      tick();
      guard++;
    end while (!r && guard < 50);
    chk("send_handshake", 64'(r), 64'(1));
    $display("sample %0d accepted remaining=%0d", $signed(v), remaining);
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    chk("done_seen", 64'(done), 64'(1));
    $display("burst done min=%0d max=%0d valid=%0b", $signed(result_min), $signed(result_max), result_valid);
  endtask

  initial begin
    int base;
    fork
      compare_loop();
    join_none

    // reset state
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rmin", 64'(result_min), 64'(0));
    chk("rst_rem", 64'(remaining), 64'(0));
    reset_n = 1;
    tick();

    // 1: count=4, valid held, done two edges after last accept
    do_start(4);
    send_one(32'd5, 0);
    send_one(-32'sd3, 0);
    send_one(32'd12, 0);
    send_one(32'd0, 0);
    in_valid = 0;
    chk("t1_done_early", 64'(done), 64'(0));
    tick();
    chk("t1_done_early2", 64'(done), 64'(0));
    tick();
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_min", 64'(result_min), 64'(32'hFFFF_FFFD));
    chk("t1_max", 64'(result_max), 64'(32'd12));
    chk("t1_valid", 64'(result_valid), 64'(1));
    $display("t1 min=%0d max=%0d", $signed(result_min), $signed(result_max));

    // 2: started in the done cycle; gapped valid, all sevens
    base = load_pulses;
    do_start(3);
    send_one(32'd7, 2);
    send_one(32'd7, 2);
    send_one(32'd7, 2);
    wait_done();
    chk("t2_min", 64'(result_min), 64'(32'd7));
    chk("t2_max", 64'(result_max), 64'(32'd7));
    chk("t2_loads", 64'(load_pulses - base), 64'(3));
    tick();

    // 3: extreme values
    do_start(2);
    send_one(32'h8000_0000, 0);
    send_one(32'h7FFF_FFFF, 0);
    in_valid = 0;
    wait_done();
    chk("t3_min", 64'(result_min), 64'(32'h8000_0000));
    chk("t3_max", 64'(result_max), 64'(32'h7FFF_FFFF));
    tick();

    // 4: abort after 2 of 5, then single-sample burst
    do_start(5);
    send_one(32'd40, 0);
    send_one(32'd41, 0);
    in_valid = 0; abort = 1;
    tick();
    abort = 0;
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_rv", 64'(result_valid), 64'(0));
    chk("t4_rem", 64'(remaining), 64'(0));
    $display("abort busy=%0b result_valid=%0b", busy, result_valid);
    repeat (3) tick();
    do_start(1);
    send_one(-32'sd9, 0);
    in_valid = 0;
    wait_done();
    chk("t4_min", 64'(result_min), 64'(32'hFFFF_FFF7));
    chk("t4_max", 64'(result_max), 64'(32'hFFFF_FFF7));
    tick();

    // 5: zero count rejected; start while busy ignored
    do_start(0);
    chk("t5_err", 64'(err_zero), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    tick();
    chk("t5_err_clr", 64'(err_zero), 64'(0));
    do_start(2);
    start = 1; count = 7;
    repeat (2) tick();
    start = 0;
    chk("t5_rem", 64'(remaining), 64'(2));
    send_one(32'd1, 0);
    send_one(32'd2, 0);
    in_valid = 0;
    wait_done();
    chk("t5_min", 64'(result_min), 64'(32'd1));
    chk("t5_max", 64'(result_max), 64'(32'd2));
    tick();

    // 6: reset mid-ACCEPT, then a fresh burst
    do_start(3);
    send_one(32'd33, 0);
    in_valid = 0;
    reset_n = 0;
    #1;
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_ready", 64'(in_ready), 64'(0));
    chk("t6_rem", 64'(remaining), 64'(0));
    chk("t6_data", 64'(dp_data), 64'(0));
    $display("reset mid-burst busy=%0b remaining=%0d", busy, remaining);
    repeat (2) tick();
    reset_n = 1;
    tick();
    do_start(2);
    send_one(-32'sd1, 0);
    send_one(32'd100, 0);
    in_valid = 0;
    wait_done();
    chk("t6_min", 64'(result_min), 64'(32'hFFFF_FFFF));
    chk("t6_max", 64'(result_max), 64'(32'd100));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
